// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32 core: fetch/decode/execute/memory/writeback with trap handling.
// Optional retire counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             fault,
    output logic [1:0]       fault_cause,
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    output logic [CNT_W-1:0] retire_cnt,
`endif
    output logic [3:0]       state_o
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_R     = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_TRAP     = 4'd9;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Counter is one bit wider than needed to reach TIMEOUT_CYC so it can saturate harmlessly.
    localparam int              WC_W    = $clog2(TIMEOUT_CYC + 2);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    if (CNT_W < 1 || TIMEOUT_CYC < 0) begin : g_param_check
        $error("multicycle_ctrl: CNT_W must be >= 1 and TIMEOUT_CYC >= 0");
    end

    logic [3:0]      r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic [1:0]      r_fault_cause;
    logic [3:0]      w_next;
    logic            w_cause_set;
    logic [1:0]      w_cause_val;
    logic            w_waiting;
    logic            w_timeout;

    always_comb begin
        w_next      = r_state;
        w_cause_set = 1'b0;
        w_cause_val = 2'b00;
        w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                      && !mem_ready;
        w_timeout   = (TIMEOUT_CYC > 0) && w_waiting && (r_wait_cnt == WC_LAST);
        case (r_state)
            S_RST:      w_next = S_FETCH;
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    w_next = S_EXEC_R;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    w_next = S_MEM_ADDR;
                end else begin
                    w_next      = S_TRAP;
                    w_cause_set = 1'b1;
                    w_cause_val = 2'b01;
                end
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_WB_R:     w_next = S_FETCH;
            S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
            S_WB_MEM:   w_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_RST;
        endcase
        // A memory that answers on the last allowed cycle still completes normally.
        if (w_timeout) begin
            w_next      = S_TRAP;
            w_cause_set = 1'b1;
            w_cause_val = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RST;
            r_wait_cnt    <= '0;
            r_fault_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_waiting && (r_wait_cnt != {WC_W{1'b1}})) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_cause_set) begin
                r_fault_cause <= w_cause_val;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_op     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault       = (r_state == S_TRAP);
    assign fault_cause = r_fault_cause;
    assign state_o     = r_state;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (instr_done && (r_state != S_TRAP)) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction runs plus trap/timeout/reset sequences.
module tb_multicycle_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6,
                           S_WB_R = 4'd7, S_WB_MEM = 4'd8, S_TRAP = 4'd9;
    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
    logic       reg_write, mem_to_reg, instr_done, fault;
    logic [1:0] alu_op, alu_src_b, fault_cause;
    logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
`endif

    multicycle_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .fault(fault), .fault_cause(fault_cause),
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    typedef struct {
        string      name;
        logic [6:0] op;
        int         fw;
        int         dw;
        int         len;
        logic [47:0] seq;
        int         n_rw;
        int         n_we;
    } vec_t;

    vec_t vecs[7];

    wire [9:0] w_outs = {mem_req, mem_we, iord, alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {mem_req, mem_we, iord, alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg}
    function automatic logic [9:0] exp_outs(input logic [3:0] s);
        case (s)
            S_FETCH:    return 10'b1_0_0_00_0_01_0_0;
            S_EXEC_R:   return 10'b0_0_0_01_1_00_0_0;
            S_MEM_ADDR: return 10'b0_0_0_00_1_10_0_0;
            S_MEM_RD:   return 10'b1_0_1_00_0_00_0_0;
            S_MEM_WR:   return 10'b1_1_1_00_0_00_0_0;
            S_WB_R:     return 10'b0_0_0_00_0_00_1_0;
            S_WB_MEM:   return 10'b0_0_0_00_0_00_1_1;
            default:    return 10'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int fw = v.fw;
        int dw = v.dw;
        int n_rw = 0;
        int n_we = 0;
        int n_done = 0;
        logic [3:0] st;
        logic exp_done;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        logic [CNT_W-1:0] rc0 = retire_cnt;
`endif
        opcode = v.op;
        exp_q.push_back(v.len);
        for (int c = 0; c < v.len; c++) begin
            st = state_o;
            chk({v.name, " state"}, 32'(st), 32'(v.seq[4*c +: 4]));
            case (st)
                S_FETCH: begin
                    mem_ready = (fw == 0);
                    if (fw > 0) fw--;
                end
                S_MEM_RD, S_MEM_WR: begin
                    mem_ready = (dw == 0);
                    if (dw > 0) dw--;
                end
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk({v.name, " outs"}, 32'(w_outs), 32'(exp_outs(st)));
            chk({v.name, " ir_write"}, 32'(ir_write), 32'(st == S_FETCH && mem_ready));
            chk({v.name, " pc_write"}, 32'(pc_write), 32'(st == S_FETCH && mem_ready));
            exp_done = (st == S_WB_R) || (st == S_WB_MEM) || (st == S_MEM_WR && mem_ready);
            chk({v.name, " instr_done"}, 32'(instr_done), 32'(exp_done));
            chk({v.name, " fault"}, 32'(fault), 32'd0);
            if (instr_done) begin
                n_done++;
                if (exp_q.size() > 0) chk({v.name, " latency"}, 32'(c + 1), 32'(exp_q.pop_front()));
                else chk({v.name, " extra done"}, 32'd1, 32'd0);
            end
            if (reg_write) n_rw++;
            if (mem_we) n_we++;
            tick();
        end
        chk({v.name, " back to FETCH"}, 32'(state_o), 32'(S_FETCH));
        chk({v.name, " done count"}, 32'(n_done), 32'd1);
        chk({v.name, " reg_write cycles"}, 32'(n_rw), 32'(v.n_rw));
        chk({v.name, " mem_we cycles"}, 32'(n_we), 32'(v.n_we));
        chk({v.name, " pending done"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk({v.name, " retire_cnt"}, retire_cnt, rc0 + 1);
`endif
    endtask

    task automatic reset_to_fetch(input string name);
        rst_n = 1'b0;
        #1;
        chk({name, " rst state"}, 32'(state_o), 32'(S_RST));
        chk({name, " rst outs"}, 32'({w_outs, ir_write, pc_write, instr_done}), 32'd0);
        chk({name, " rst fault"}, 32'({fault, fault_cause}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk({name, " rst->FETCH"}, 32'(state_o), 32'(S_FETCH));
    endtask

    initial begin
        vecs[0] = '{"R",        OP_R,  0, 0, 4,  48'h7321,        1, 0};
        vecs[1] = '{"LD w3",    OP_LD, 0, 3, 8,  48'h85555421,    1, 0};
        vecs[2] = '{"ST",       OP_ST, 0, 0, 4,  48'h6421,        0, 1};
        vecs[3] = '{"ST w2",    OP_ST, 0, 2, 6,  48'h666421,      0, 3};
        vecs[4] = '{"LD",       OP_LD, 0, 0, 5,  48'h85421,       1, 0};
        vecs[5] = '{"R fw2",    OP_R,  2, 0, 6,  48'h732111,      1, 0};
        vecs[6] = '{"LD fw3w3", OP_LD, 3, 3, 11, 48'h85555421111, 1, 0};

        mem_ready = 1'b1;
        #2;
        chk("reset state", 32'(state_o), 32'(S_RST));
        chk("reset outs", 32'({w_outs, ir_write, pc_write, instr_done}), 32'd0);
        chk("reset fault", 32'({fault, fault_cause}), 32'd0);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("reset retire_cnt", retire_cnt, 0);
`endif
        tick();
        chk("held in reset", 32'(state_o), 32'(S_RST));
        rst_n = 1'b1;
        tick();
        chk("RST->FETCH", 32'(state_o), 32'(S_FETCH));

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset asserted asynchronously while a store waits on memory.
        opcode = OP_ST;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("pre-rst MEM_WR", 32'(state_o), 32'(S_MEM_WR));
        chk("pre-rst mem_we", 32'(mem_we), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst state", 32'(state_o), 32'(S_RST));
        chk("mid rst outs", 32'({w_outs, ir_write, pc_write, instr_done}), 32'd0);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("mid rst retire_cnt", retire_cnt, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid rst->FETCH", 32'(state_o), 32'(S_FETCH));
        run_vec(vecs[0]);
        run_vec(vecs[4]);
        run_vec(vecs[2]);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("retire_cnt after 3", retire_cnt, 3);
`endif

        // Illegal opcode traps from DECODE and stays trapped.
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        tick();
        chk("illegal DECODE", 32'(state_o), 32'(S_DECODE));
        tick();
        chk("illegal TRAP", 32'(state_o), 32'(S_TRAP));
        chk("illegal cause", 32'({fault, fault_cause}), 32'({1'b1, 2'b01}));
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("trap state", 32'(state_o), 32'(S_TRAP));
            chk("trap outs", 32'({w_outs, ir_write, pc_write, instr_done}), 32'd0);
            chk("trap fault", 32'({fault, fault_cause}), 32'({1'b1, 2'b01}));
            tick();
        end
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        chk("trap retire frozen", retire_cnt, 3);
`endif
        reset_to_fetch("after illegal");

        // Fetch timeout: four unanswered cycles trap.
        mem_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("timeout waiting", 32'(state_o), 32'(S_FETCH));
            tick();
        end
        chk("timeout TRAP", 32'(state_o), 32'(S_TRAP));
        chk("timeout cause", 32'({fault, fault_cause}), 32'({1'b1, 2'b10}));
        reset_to_fetch("after timeout");

        // Ready arriving on the last allowed cycle wins.
        mem_ready = 1'b0;
        opcode = OP_R;
        for (int i = 0; i < TO - 1; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("late ready ir_write", 32'(ir_write), 32'd1);
        tick();
        chk("late ready DECODE", 32'(state_o), 32'(S_DECODE));
        chk("late ready no fault", 32'({fault, fault_cause}), 32'd0);
        reset_to_fetch("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
